// File: rtl/lbp_table_scheduler_if.sv
// Bundles the prediction, update and counter-SRAM buses around the table scheduler.
// slave is the scheduler's view; master is the surrounding frontend/resolve/RAM side.
interface lbp_table_scheduler_if #(
  parameter int NR_ROWS         = 64,
  parameter int INSTR_PER_FETCH = 2
);
  localparam int ROW_BITS  = $clog2(NR_ROWS);
  localparam int SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int ROW_W     = 2 * INSTR_PER_FETCH;

  logic                 pred_req_i;
  logic [ROW_BITS-1:0]  pred_index_i;
  logic                 pred_gnt_o;
  logic                 pred_rvalid_o;
  logic [ROW_W-1:0]     pred_rdata_o;

  logic                 upd_valid_i;
  logic                 upd_ready_o;
  logic [ROW_BITS-1:0]  upd_index_i;
  logic [SLOT_BITS-1:0] upd_slot_i;
  logic                 upd_taken_i;

  logic                 sram_req_o;
  logic                 sram_we_o;
  logic [ROW_BITS-1:0]  sram_addr_o;
  logic [ROW_W-1:0]     sram_wdata_o;
  logic [ROW_W-1:0]     sram_rdata_i;

  modport slave (
    input  pred_req_i, pred_index_i, upd_valid_i, upd_index_i, upd_slot_i, upd_taken_i,
           sram_rdata_i,
    output pred_gnt_o, pred_rvalid_o, pred_rdata_o, upd_ready_o,
           sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output pred_req_i, pred_index_i, upd_valid_i, upd_index_i, upd_slot_i, upd_taken_i,
           sram_rdata_i,
    input  pred_gnt_o, pred_rvalid_o, pred_rdata_o, upd_ready_o,
           sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o
  );
endinterface

// File: rtl/lbp_table_scheduler.sv
// Single-port owner of the local-predictor counter SRAM: init sweep, prediction reads
// and FIFO-buffered read-modify-write counter updates.
module lbp_table_scheduler #(
  parameter int         NR_ROWS         = 64,
  parameter int         INSTR_PER_FETCH = 2,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [1:0] INIT_CTR        = 2'b01
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_bp_i,
  input  logic                   debug_mode_i,
  output logic                   init_done_o,
  lbp_table_scheduler_if.slave   bus
);
  localparam int ROW_BITS  = $clog2(NR_ROWS);
  localparam int SLOT_BITS = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
  localparam int ROW_W     = 2 * INSTR_PER_FETCH;
  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);

  localparam logic [PTR_BITS:0]   PTR_ONE  = 1;
  localparam logic [ROW_BITS-1:0] ROW_ONE  = 1;
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(NR_ROWS - 1);

  typedef enum logic [1:0] {SWEEP, IDLE, UPD_RD, UPD_WR} state_t;

  state_t               r_state;
  logic [ROW_BITS-1:0]  r_sweep_cnt;
  logic                 r_init_done;
  logic                 r_pred_rvalid;
  logic [ROW_W-1:0]     r_row;

  logic [ROW_BITS-1:0]  r_fifo_idx   [FIFO_DEPTH];
  logic [SLOT_BITS-1:0] r_fifo_slot  [FIFO_DEPTH];
  logic                 r_fifo_taken [FIFO_DEPTH];
  logic [PTR_BITS:0]    r_wr_ptr;
  logic [PTR_BITS:0]    r_rd_ptr;

  logic                 w_fifo_empty;
  logic                 w_fifo_full;
  logic                 w_active;
  logic                 w_idle;
  logic                 w_pred_gnt;
  logic                 w_upd_start;
  logic                 w_upd_ready;
  logic                 w_push;
  logic                 w_pop;
  logic [ROW_BITS-1:0]  w_head_idx;
  logic [SLOT_BITS-1:0] w_head_slot;
  logic                 w_head_taken;
  logic [ROW_W-1:0]     w_upd_row;
  logic [ROW_W-1:0]     w_init_row;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_BITS] != r_rd_ptr[PTR_BITS]) &&
                        (r_wr_ptr[PTR_BITS-1:0] == r_rd_ptr[PTR_BITS-1:0]);

  // Reset and flush both silence every request-side action in the cycle they are seen.
  assign w_active    = !rst_i && !flush_bp_i;
  assign w_idle      = w_active && (r_state == IDLE);
  assign w_pred_gnt  = w_idle && bus.pred_req_i && !w_fifo_full;
  assign w_upd_start = w_idle && !w_fifo_empty && (!bus.pred_req_i || w_fifo_full);
  assign w_upd_ready = w_active && !w_fifo_full && (r_state != SWEEP);
  assign w_push      = bus.upd_valid_i && w_upd_ready && !debug_mode_i;
  assign w_pop       = w_active && (r_state == UPD_WR);

  assign w_head_idx   = r_fifo_idx[r_rd_ptr[PTR_BITS-1:0]];
  assign w_head_slot  = r_fifo_slot[r_rd_ptr[PTR_BITS-1:0]];
  assign w_head_taken = r_fifo_taken[r_rd_ptr[PTR_BITS-1:0]];
  assign w_init_row   = {INSTR_PER_FETCH{INIT_CTR}};

  // Only the head slot moves; its neighbours are written back exactly as read.
  generate
    for (genvar gi = 0; gi < INSTR_PER_FETCH; gi++) begin : g_slot
      logic [1:0] w_ctr;
      logic [1:0] w_ctr_next;
      assign w_ctr      = r_row[2*gi +: 2];
      assign w_ctr_next = w_head_taken ? ((w_ctr == 2'b11) ? 2'b11 : w_ctr + 2'd1)
                                       : ((w_ctr == 2'b00) ? 2'b00 : w_ctr - 2'd1);
      assign w_upd_row[2*gi +: 2] = (w_head_slot == SLOT_BITS'(gi)) ? w_ctr_next : w_ctr;
    end
  endgenerate

  always_comb begin
    bus.sram_req_o   = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    if (w_active) begin
      case (r_state)
        SWEEP: begin
          bus.sram_req_o   = 1'b1;
          bus.sram_we_o    = 1'b1;
          bus.sram_addr_o  = r_sweep_cnt;
          bus.sram_wdata_o = w_init_row;
        end
        IDLE: begin
          if (w_pred_gnt) begin
            bus.sram_req_o  = 1'b1;
            bus.sram_addr_o = bus.pred_index_i;
          end else if (w_upd_start) begin
            bus.sram_req_o  = 1'b1;
            bus.sram_addr_o = w_head_idx;
          end
        end
        UPD_WR: begin
          bus.sram_req_o   = 1'b1;
          bus.sram_we_o    = 1'b1;
          bus.sram_addr_o  = w_head_idx;
          bus.sram_wdata_o = w_upd_row;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_bp_i) begin
      r_state       <= SWEEP;
      r_sweep_cnt   <= '0;
      r_init_done   <= 1'b0;
      r_pred_rvalid <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_pred_rvalid <= w_pred_gnt;
      if (w_push) begin
        r_fifo_idx[r_wr_ptr[PTR_BITS-1:0]]   <= bus.upd_index_i;
        r_fifo_slot[r_wr_ptr[PTR_BITS-1:0]]  <= bus.upd_slot_i;
        r_fifo_taken[r_wr_ptr[PTR_BITS-1:0]] <= bus.upd_taken_i;
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case (r_state)
        SWEEP: begin
          r_sweep_cnt <= r_sweep_cnt + ROW_ONE;
          if (r_sweep_cnt == ROW_LAST) begin
            r_state     <= IDLE;
            r_init_done <= 1'b1;
          end
        end
        IDLE: begin
          if (w_upd_start) r_state <= UPD_RD;
        end
        UPD_RD: begin
          r_row   <= bus.sram_rdata_i;
          r_state <= UPD_WR;
        end
        UPD_WR: r_state <= IDLE;
        default: r_state <= SWEEP;
      endcase
    end
  end

  assign init_done_o       = r_init_done && !rst_i;
  assign bus.pred_gnt_o    = w_pred_gnt;
  assign bus.pred_rvalid_o = r_pred_rvalid && !rst_i;
  assign bus.pred_rdata_o  = bus.pred_rvalid_o ? bus.sram_rdata_i : '0;
  assign bus.upd_ready_o   = w_upd_ready;
endmodule

// File: tb/tb_lbp_table_scheduler.sv
// Directed bench for lbp_table_scheduler: SRAM model, table-level reference model with a
// per-cycle compare process, plus literal read-back expectations.
module tb_lbp_table_scheduler;
  logic clk = 1'b0;
  logic rst, flush, debug, init_done;
  int   checks = 0;
  int   errors = 0;

  lbp_table_scheduler_if bus ();

  lbp_table_scheduler dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_bp_i  (flush),
    .debug_mode_i(debug),
    .init_done_o (init_done),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Single-port SRAM with registered read data
  logic [3:0] mem [64];
  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      else               bus.sram_rdata_i     <= mem[bus.sram_addr_o];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] apply_upd(input logic [3:0] row, input int slot, input bit taken);
    int c;
    c = int'(row[2*slot +: 2]);
    if (taken) c = (c < 3) ? c + 1 : 3;
    else       c = (c > 0) ? c - 1 : 0;
    row[2*slot +: 2] = c[1:0];
    return row;
  endfunction

  // Reference: table contents after every accepted update, in acceptance order, and the
  // queue of row writes those updates must eventually produce.
  bit         sweeping = 1'b1;
  int         sweep_exp = 0;
  logic [3:0] tab [64];
  logic [5:0] wq_idx [$];
  logic [3:0] wq_dat [$];
  bit         pend_v = 1'b0;
  logic [3:0] pend_d;

  task automatic model_restart();
    sweeping  = 1'b1;
    sweep_exp = 0;
    wq_idx.delete();
    wq_dat.delete();
    for (int i = 0; i < 64; i++) tab[i] = 4'b0101;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outs", 32'({init_done, bus.pred_rvalid_o, bus.upd_ready_o, bus.pred_gnt_o,
                           bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o}), 32'd0);
      model_restart();
      pend_v = 1'b0;
    end else begin
      chk("rvalid", 32'(bus.pred_rvalid_o), 32'(pend_v));
      if (pend_v) chk("rdata", 32'(bus.pred_rdata_o), 32'(pend_d));
      chk("init_done", 32'(init_done), 32'(!sweeping));
      pend_v = bus.pred_gnt_o;
      pend_d = mem[bus.pred_index_i];
      if (bus.pred_gnt_o)
        chk("gnt_access", 32'({bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o}),
            32'({1'b1, 1'b0, bus.pred_index_i}));
      if (flush) begin
        chk("flush_quiet", 32'({bus.pred_gnt_o, bus.upd_ready_o, bus.sram_req_o}), 32'd0);
        model_restart();
        pend_v = 1'b0;
      end else begin
        chk("upd_ready", 32'(bus.upd_ready_o), 32'(!sweeping && wq_idx.size() < 4));
        chk("gnt_legal", 32'(bus.pred_gnt_o && !(bus.pred_req_i && !sweeping && wq_idx.size() < 4)), 32'd0);
        if (sweeping) begin
          chk("sweep_wr", 32'({bus.sram_req_o, bus.sram_we_o, bus.sram_addr_o, bus.sram_wdata_o}),
              32'({1'b1, 1'b1, 6'(sweep_exp), 4'b0101}));
          sweep_exp++;
          if (sweep_exp == 64) sweeping = 1'b0;
        end else if (bus.sram_req_o && bus.sram_we_o) begin
          if (wq_idx.size() == 0) begin
            chk("unexpected_wr", 32'(bus.sram_addr_o), 32'hFFFF_FFFF);
          end else begin
            chk("upd_wr", 32'({bus.sram_addr_o, bus.sram_wdata_o}),
                32'({wq_idx.pop_front(), wq_dat.pop_front()}));
          end
        end
        if (bus.upd_valid_i && bus.upd_ready_o && !debug) begin
          tab[bus.upd_index_i] = apply_upd(tab[bus.upd_index_i], int'(bus.upd_slot_i), bus.upd_taken_i);
          wq_idx.push_back(bus.upd_index_i);
          wq_dat.push_back(tab[bus.upd_index_i]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pred_read(input logic [5:0] idx, input logic [3:0] exp, input string nm, input bit same_cycle);
    int n = 0;
    bus.pred_req_i   = 1'b1;
    bus.pred_index_i = idx;
    @(negedge clk);
    while (!bus.pred_gnt_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    step();
    bus.pred_req_i = 1'b0;
    chk({nm, "_gnt_wait"}, 32'(n < 200), 32'd1);
    if (n < 200) begin
      if (same_cycle) chk({nm, "_same_cycle"}, 32'(n), 32'd0);
      @(negedge clk);
      chk({nm, "_data"}, 32'({bus.pred_rvalid_o, bus.pred_rdata_o}), 32'({1'b1, exp}));
      step();
    end
  endtask

  task automatic push_upd(input logic [5:0] idx, input logic slot, input logic taken);
    int n = 0;
    bus.upd_valid_i = 1'b1;
    bus.upd_index_i = idx;
    bus.upd_slot_i  = slot;
    bus.upd_taken_i = taken;
    @(negedge clk);
    while (!bus.upd_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    step();
    bus.upd_valid_i = 1'b0;
    chk("push_wait", 32'(n < 200), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (wq_idx.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    step();
    chk("drain_wait", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; debug = 1'b0;
    bus.pred_req_i = 1'b0; bus.pred_index_i = '0;
    bus.upd_valid_i = 1'b0; bus.upd_index_i = '0; bus.upd_slot_i = '0; bus.upd_taken_i = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Sweep: 64 writes, table valid on the 65th cycle after reset release
    repeat (64) step();
    @(negedge clk);
    chk("init_at_65", 32'(init_done), 32'd1);
    step();

    pred_read(6'd5, 4'b0101, "row5_init", 1'b1);

    // Four taken updates to row 3 slot 1 while predictions keep the port busy
    bus.pred_req_i = 1'b1; bus.pred_index_i = 6'd3;
    repeat (4) push_upd(6'd3, 1'b1, 1'b1);
    @(negedge clk);
    chk("full_blocks", 32'({bus.pred_gnt_o, bus.upd_ready_o}), 32'd0);
    step();
    bus.pred_req_i = 1'b0;
    drain();
    pred_read(6'd3, 4'b1101, "row3_sat", 1'b1);

    // Not-taken saturation at zero on row 7 slot 0
    push_upd(6'd7, 1'b0, 1'b0);
    drain();
    push_upd(6'd7, 1'b0, 1'b0);
    drain();
    pred_read(6'd7, 4'b0100, "row7_nt2", 1'b1);
    push_upd(6'd7, 1'b0, 1'b0);
    drain();
    pred_read(6'd7, 4'b0100, "row7_nt3", 1'b1);

    // Flush while an update read is in flight with three entries buffered
    bus.pred_req_i = 1'b1; bus.pred_index_i = 6'd0;
    push_upd(6'd10, 1'b0, 1'b1);
    push_upd(6'd11, 1'b1, 1'b1);
    push_upd(6'd12, 1'b0, 1'b0);
    bus.pred_req_i = 1'b0;
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", 32'({bus.upd_ready_o, bus.sram_req_o}), 32'd0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("resweep_row0", 32'({bus.sram_we_o, bus.sram_addr_o}), 32'({1'b1, 6'd0}));
    repeat (64) step();
    pred_read(6'd3,  4'b0101, "row3_after_flush", 1'b1);
    pred_read(6'd7,  4'b0101, "row7_after_flush", 1'b1);
    pred_read(6'd10, 4'b0101, "row10_after_flush", 1'b1);

    // Debug mode: updates are accepted immediately and dropped
    debug = 1'b1;
    push_upd(6'd20, 1'b0, 1'b1);
    push_upd(6'd21, 1'b1, 1'b0);
    debug = 1'b0;
    repeat (10) step();
    pred_read(6'd20, 4'b0101, "row20_debug", 1'b1);
    pred_read(6'd21, 4'b0101, "row21_debug", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
